regfile_wr_arbiter: RTL and testbench

Owns the single write port (wa3/wd3/we3) of the 32 x 64-bit register file.
- After reset, sequences a clear pass that writes zero to X0..X30.
- Then shares the write port between two writeback requesters (0: ALU path, 1: memory/load path) using round-robin arbitration with a valid/ready handshake.
- Sits between the writeback stage and the regfile; read ports are untouched.

---
 rtl/regfile_wr_arbiter_if.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 61 ++++++
 tb/tb_regfile_wr_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: writeback requesters plus regfile write-port bundle
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr, wa3;
    logic [DATA_W-1:0] req0_data, req1_data, wd3;
    logic              init_done, we3;
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, init_done, wa3, wd3, we3
    );
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, init_done, wa3, wd3, we3
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: clears X0..X30 after reset, then round-robin shares the regfile write port
module regfile_wr_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int N_REGS   = 32,
    parameter int ZERO_REG = 31
) (
    input logic clk,
    input logic reset,
    regfile_wr_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_cnt, r_wa3, w_addr;
    logic [DATA_W-1:0] r_wd3, w_data;
    logic              r_prio, r_we3, r_init_done, w_gnt0, w_gnt1, w_last, w_xfer, w_wr;
    always_comb begin
        w_gnt1 = bus.req1_valid && (!bus.req0_valid || r_prio);
        w_gnt0 = bus.req0_valid && !w_gnt1;
        w_xfer = (r_state == RUN) && (w_gnt0 || w_gnt1);
        w_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
        w_data = w_gnt1 ? bus.req1_data : bus.req0_data;
        w_wr   = w_xfer && (w_addr != ADDR_W'(ZERO_REG));
        w_last = r_cnt == ADDR_W'(N_REGS - 2);
        w_next = (r_state == INIT && w_last) ? RUN : r_state;
    end
    assign bus.req0_ready = (r_state == RUN) && w_gnt0;
    assign bus.req1_ready = (r_state == RUN) && w_gnt1;
    assign bus.we3        = r_we3;
    assign bus.wa3        = r_wa3;
    assign bus.wd3        = r_wd3;
    assign bus.init_done  = r_init_done;
    always_ff @(posedge clk) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_prio      <= 1'b0;
            r_we3       <= 1'b0;
            r_wa3       <= '0;
            r_wd3       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == INIT) begin
            r_we3       <= 1'b1;
            r_wa3       <= r_cnt;
            r_wd3       <= '0;
            r_cnt       <= r_cnt + 1'b1;
            r_init_done <= w_last;
        end else begin
            r_we3 <= w_wr;
            // the loser of this transfer wins the next tie, even for dropped XZR writes
            if (w_xfer) r_prio <= w_gnt0;
            if (w_wr) begin
                r_wa3 <= w_addr;
                r_wd3 <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random writeback traffic checked against a cycle model
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus ();
    regfile_wr_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    logic        v [2];
    logic [4:0]  a [2];
    logic [63:0] d [2];
    assign bus.req0_valid = v[0];
    assign bus.req0_addr  = a[0];
    assign bus.req0_data  = d[0];
    assign bus.req1_valid = v[1];
    assign bus.req1_addr  = a[1];
    assign bus.req1_data  = d[1];

    logic [63:0] rf [32];
    always_ff @(posedge clk) if (bus.we3) rf[bus.wa3] <= bus.wd3;

    int checks = 0, failures = 0;
    bit m_run, m_init, m_we;
    int m_cnt, m_prio, xfer;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    logic [63:0] m_rf [32];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int g;
        @(negedge clk);
        g = -1;
        if (m_run) begin
            if (v[0] && v[1]) g = m_prio;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
        end
        chk("req0_ready", 64'(bus.req0_ready), 64'(g == 0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(g == 1));
        chk("we3", 64'(bus.we3), 64'(m_we));
        chk("wa3", 64'(bus.wa3), 64'(m_wa));
        chk("wd3", bus.wd3, m_wd);
        chk("init_done", 64'(bus.init_done), 64'(m_init));
        xfer = -1;
        if (reset) begin
            m_run = 0; m_init = 0; m_cnt = 0; m_prio = 0;
            m_we = 0; m_wa = '0; m_wd = '0;
        end else if (!m_run) begin
            m_we = 1; m_wa = 5'(m_cnt); m_wd = '0;
            m_rf[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 31) begin m_run = 1; m_init = 1; end
        end else begin
            xfer = g;
            m_we = 0;
            if (g >= 0) begin
                m_prio = 1 - g;
                if (a[g] != 5'd31) begin
                    m_we = 1; m_wa = a[g]; m_wd = d[g];
                    m_rf[a[g]] = d[g];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cycle();
        if (xfer >= 0) v[xfer] = 1'b0;
    endtask

    task automatic check_rf();
        for (int i = 0; i < 31; i++) chk($sformatf("rf_x%0d", i), rf[i], m_rf[i]);
    endtask

    initial begin
        v[0] = 0; v[1] = 0; a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
        m_run = 0; m_init = 0; m_we = 0; m_cnt = 0; m_prio = 0; m_wa = '0; m_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        repeat (40) cycle();
        check_rf();

        v[0] = 1; a[0] = 5'd1; d[0] = 64'hA;
        v[1] = 1; a[1] = 5'd2; d[1] = 64'hB;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (xfer >= 0) d[xfer] = d[xfer] + 64'h10;
        end
        v[0] = 0; v[1] = 0;
        repeat (2) cycle();
        chk("x1_after_tie", rf[1], 64'h1A);
        chk("x2_after_tie", rf[2], 64'h1B);

        v[0] = 1; a[0] = 5'd18; d[0] = 64'd69;
        repeat (3) step();
        chk("x18", rf[18], 64'd69);

        v[1] = 1; a[1] = 5'd31; d[1] = 64'd9;
        repeat (2) step();
        v[0] = 1; a[0] = 5'd3; d[0] = 64'd33;
        v[1] = 1; a[1] = 5'd4; d[1] = 64'd44;
        repeat (3) step();
        chk("x3", rf[3], 64'd33);
        chk("x4", rf[4], 64'd44);

        v[0] = 1; a[0] = 5'd7; d[0] = 64'd77;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (40) step();
        chk("x7_after_reset", rf[7], 64'd77);
        chk("x18_cleared", rf[18], 64'd0);
        check_rf();

        for (int k = 0; k < 800; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && $urandom_range(0, 2) != 0) begin
                    v[n] = 1'b1;
                    a[n] = 5'($urandom_range(0, 31));
                    d[n] = {$urandom, $urandom};
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        v[0] = 0; v[1] = 0;
        repeat (40) cycle();
        check_rf();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
